// File: rtl/hash_update_arbiter.sv
// rtl/hash_update_arbiter.sv - 4-way round-robin hash-update arbiter with burst hold and registered output
// Optional HASH_ARB_STATS_EN adds per-requester grant counters and an output stall counter.
module hash_update_arbiter #(
   parameter int DATA_W    = 128,
   parameter int MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            in_valid,
   input  logic [4*DATA_W-1:0]   in_data,
   output logic [3:0]            in_ready,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_data,
   output logic [1:0]            out_sel,
   input  logic                  out_ready,
`ifdef HASH_ARB_STATS_EN
   output logic [3:0][31:0]      stat_grant_cnt,
   output logic [31:0]           stat_stall_cnt,
`endif
   output logic                  busy
);

   localparam logic [3:0] MB = 4'(MAX_BURST);

   typedef enum logic {ST_ARB, ST_HOLD} state_t;

   state_t              r_state, w_state_nxt;
   logic [1:0]          r_rr_ptr, r_owner, w_rr_nxt, w_owner_nxt;
   logic [1:0]          w_base, w_idx, w_winner, w_gidx;
   logic [3:0]          r_burst_cnt, w_burst_nxt;
   logic                w_load, w_others, w_keep, w_found, w_grant;
   logic [DATA_W-1:0]   w_gdata;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic [1:0]          r_out_sel;

   always_comb begin
      w_load      = !r_out_valid || out_ready;
      w_others    = |(in_valid & ~(4'b0001 << r_owner));
      w_keep      = (r_state == ST_HOLD) && in_valid[r_owner] &&
                    ((r_burst_cnt < MB) || !w_others);
      // Leaving HOLD searches from owner+1 in the same cycle, so no bubble
      w_base      = (r_state == ST_HOLD) ? r_owner + 2'd1 : r_rr_ptr;
      w_found     = 1'b0;
      w_winner    = 2'd0;
      w_idx       = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         w_idx = w_base + 2'(k);
         if (in_valid[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end

      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_owner_nxt = r_owner;
      w_burst_nxt = r_burst_cnt;
      w_grant     = 1'b0;
      w_gidx      = 2'd0;
      if (w_load) begin
         if (w_keep) begin
            w_grant     = 1'b1;
            w_gidx      = r_owner;
            w_burst_nxt = (r_burst_cnt < MB) ? r_burst_cnt + 4'd1 : r_burst_cnt;
         end else begin
            if (r_state == ST_HOLD)
               w_rr_nxt = r_owner + 2'd1;
            w_state_nxt = ST_ARB;
            if (w_found) begin
               w_grant = 1'b1;
               w_gidx  = w_winner;
               if (MAX_BURST == 1) begin
                  w_rr_nxt = w_winner + 2'd1;
               end else begin
                  w_owner_nxt = w_winner;
                  w_burst_nxt = 4'd1;
                  w_state_nxt = ST_HOLD;
               end
            end
         end
      end

      in_ready = 4'b0000;
      if (w_grant && rst_n)
         in_ready = 4'b0001 << w_gidx;

      w_gdata = '0;
      for (int k = 0; k < 4; k++)
         if (w_gidx == 2'(k))
            w_gdata = in_data[k*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_ARB;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_ptr    <= 2'd0;
         r_owner     <= 2'd0;
         r_burst_cnt <= 4'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= 2'd0;
      end else begin
         r_rr_ptr    <= w_rr_nxt;
         r_owner     <= w_owner_nxt;
         r_burst_cnt <= w_burst_nxt;
         if (w_load) begin
            r_out_valid <= w_grant;
            if (w_grant) begin
               r_out_data <= w_gdata;
               r_out_sel  <= w_gidx;
            end
         end
      end
   end

`ifdef HASH_ARB_STATS_EN
   logic [3:0][31:0] r_grant_cnt;
   logic [31:0]      r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_grant_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         for (int k = 0; k < 4; k++)
            if (in_valid[k] && in_ready[k])
               r_grant_cnt[k] <= r_grant_cnt[k] + 32'd1;
         if (r_out_valid && !out_ready)
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stat_grant_cnt = r_grant_cnt;
   assign stat_stall_cnt = r_stall_cnt;
`endif

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
   assign busy      = r_out_valid | (|in_valid);

endmodule
